// File: rtl/vector_alu_sequencer.sv
// Vector ALU sequencer: issues one element per cycle from the VRF into the ALU
// and writes each result back to the VRF. Pipeline is read (RUN) -> ALU/write (stage 1).
module vector_alu_sequencer #(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned LW    = 6,
    parameter int unsigned VLMAX = 32
) (
    input  logic          clk,
    input  logic          rst,
    // Command handshake from issue
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [LW-1:0] cmd_vlen,
    input  logic [AW-1:0] cmd_src1,
    input  logic [AW-1:0] cmd_src2,
    input  logic [AW-1:0] cmd_dst,
    // VRF read port (1-cycle registered latency)
    output logic          rf_rd_en,
    output logic [AW-1:0] rf_rd_addr1,
    output logic [AW-1:0] rf_rd_addr2,
    input  logic [DW-1:0] rf_rd_data1,
    input  logic [DW-1:0] rf_rd_data2,
    // ALU
    output logic          alu_ena,
    output logic [2:0]    alu_sel,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_result,
    // VRF write port
    output logic          rf_wr_en,
    output logic [AW-1:0] rf_wr_addr,
    output logic [DW-1:0] rf_wr_data,
    // Status
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    localparam logic [LW-1:0] VlmaxL = LW'(VLMAX);

    state_e        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [AW-1:0] src1_q, src1_d;
    logic [AW-1:0] src2_q, src2_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [LW-1:0] n_q, n_d;
    logic [LW-1:0] i_q, i_d;
    logic          s1_v_q, s1_v_d;
    logic [AW-1:0] s1_idx_q, s1_idx_d;

    logic          accept;
    logic [LW-1:0] vlen_clamped;
    logic          last_issue;

    assign accept       = cmd_valid && (state_q == StIdle);
    assign vlen_clamped = (cmd_vlen > VlmaxL) ? VlmaxL : cmd_vlen;
    // Only meaningful in RUN, where n_q is known to be non-zero
    assign last_issue   = (i_q == n_q - LW'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (vlen_clamped == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (last_issue) begin
                    state_d = StDrain;
                end
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Command latch, element counter and stage-1 next values
    always_comb begin
        op_d     = op_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        dst_d    = dst_q;
        n_d      = n_q;
        i_d      = i_q;
        s1_v_d   = (state_q == StRun);
        s1_idx_d = s1_idx_q;
        if (accept) begin
            op_d   = cmd_op;
            src1_d = cmd_src1;
            src2_d = cmd_src2;
            dst_d  = cmd_dst;
            n_d    = vlen_clamped;
            i_d    = '0;
        end
        if (state_q == StRun) begin
            s1_idx_d = AW'(i_q);
            i_d      = i_q + LW'(1);
        end
    end

    // Datapath registers; reset aborts any in-flight element
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            dst_q    <= '0;
            n_q      <= '0;
            i_q      <= '0;
            s1_v_q   <= 1'b0;
            s1_idx_q <= '0;
        end else begin
            op_q     <= op_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            dst_q    <= dst_d;
            n_q      <= n_d;
            i_q      <= i_d;
            s1_v_q   <= s1_v_d;
            s1_idx_q <= s1_idx_d;
        end
    end

    // Outputs: read issue in RUN, ALU/write driven straight from stage 1
    always_comb begin
        cmd_ready   = (state_q == StIdle);
        busy        = (state_q != StIdle);
        done        = (state_q == StDone);
        rf_rd_en    = (state_q == StRun);
        rf_rd_addr1 = rf_rd_en ? src1_q + AW'(i_q) : '0;
        rf_rd_addr2 = rf_rd_en ? src2_q + AW'(i_q) : '0;
        alu_ena     = s1_v_q;
        alu_sel     = s1_v_q ? op_q : 3'd0;
        alu_a       = s1_v_q ? rf_rd_data1 : '0;
        alu_b       = s1_v_q ? rf_rd_data2 : '0;
        rf_wr_en    = s1_v_q;
        rf_wr_addr  = s1_v_q ? dst_q + s1_idx_q : '0;
        rf_wr_data  = s1_v_q ? alu_result : '0;
    end

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Self-checking bench for vector_alu_sequencer with behavioural ALU and VRF models.
module tb_vector_alu_sequencer;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int LW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [LW-1:0] cmd_vlen;
    logic [AW-1:0] cmd_src1, cmd_src2, cmd_dst;
    logic          rf_rd_en;
    logic [AW-1:0] rf_rd_addr1, rf_rd_addr2;
    logic [DW-1:0] rf_rd_data1 = '0;
    logic [DW-1:0] rf_rd_data2 = '0;
    logic          alu_ena;
    logic [2:0]    alu_sel;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic          rf_wr_en;
    logic [AW-1:0] rf_wr_addr;
    logic [DW-1:0] rf_wr_data;
    logic          busy, done;

    always #5 clk = ~clk;

    vector_alu_sequencer #(.DW(DW), .AW(AW), .LW(LW), .VLMAX(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_vlen    (cmd_vlen),
        .cmd_src1    (cmd_src1),
        .cmd_src2    (cmd_src2),
        .cmd_dst     (cmd_dst),
        .rf_rd_en    (rf_rd_en),
        .rf_rd_addr1 (rf_rd_addr1),
        .rf_rd_addr2 (rf_rd_addr2),
        .rf_rd_data1 (rf_rd_data1),
        .rf_rd_data2 (rf_rd_data2),
        .alu_ena     (alu_ena),
        .alu_sel     (alu_sel),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_addr  (rf_wr_addr),
        .rf_wr_data  (rf_wr_data),
        .busy        (busy),
        .done        (done)
    );

    // ALU model
    always_comb begin
        case (alu_sel)
            3'd0:    alu_result = alu_a + alu_b;
            3'd1:    alu_result = alu_a - alu_b;
            3'd2:    alu_result = alu_a * alu_b;
            3'd3:    alu_result = 32'd254;
            default: alu_result = '0;
        endcase
    end

    // VRF model: registered read, read-before-write, plus bench clear/preload
    logic [DW-1:0] vrf [32];
    logic          clr = 1'b0;
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (clr) begin
            for (int j = 0; j < 32; j++) vrf[j] <= '0;
        end else if (pl_en) begin
            vrf[pl_addr] <= pl_data;
        end else if (rf_wr_en) begin
            vrf[rf_wr_addr] <= rf_wr_data;
        end
        if (rf_rd_en) begin
            rf_rd_data1 <= vrf[rf_rd_addr1];
            rf_rd_data2 <= vrf[rf_rd_addr2];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: logs traffic and counts invariant violations
    logic [AW-1:0] wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];
    logic [AW-1:0] rd_addr_q [$];
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   inv_cnt  = 0;
    logic mon_on   = 1'b0;
    logic [2:0] cur_op = '0;

    always @(negedge clk) begin
        if (rf_wr_en) begin
            wr_addr_q.push_back(rf_wr_addr);
            wr_data_q.push_back(rf_wr_data);
        end
        if (rf_rd_en) rd_addr_q.push_back(rf_rd_addr1);
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (mon_on) begin
            if (alu_ena != rf_wr_en) inv_cnt = inv_cnt + 1;
            if (!alu_ena && ((alu_a | alu_b | rf_wr_data) != '0)) inv_cnt = inv_cnt + 1;
            if (cmd_ready == busy) inv_cnt = inv_cnt + 1;
            if (done && !busy) inv_cnt = inv_cnt + 1;
            if (alu_ena && (alu_sel != cur_op)) inv_cnt = inv_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic clear_vrf();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [LW-1:0] vlen,
                         input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                         input logic [AW-1:0] d, output int acc);
        int guard = 0;
        while (!cmd_ready && guard < 100) begin
            tick();
            guard++;
        end
        check("ready_before_issue", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_vlen  = vlen;
        cmd_src1  = s1;
        cmd_src2  = s2;
        cmd_dst   = d;
        cur_op    = op;
        acc       = cyc;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output logic ok);
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            if (done_cnt > d0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("done_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [2:0]    op;
        logic [LW-1:0] vlen;
        logic [AW-1:0] s1, s2, d;
        logic [DW-1:0] abase, bval, first, step;
        int            n;
        int            lat;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input vec_t v, input int idx);
        int   acc, wb, rb, d0;
        logic ok;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        clear_vrf();
        for (int k = 0; k < v.n; k++) begin
            write_word(v.s1 + AW'(k), v.abase + DW'(k));
            write_word(v.s2 + AW'(k), v.bval);
        end
        wb = wr_addr_q.size();
        rb = rd_addr_q.size();
        d0 = done_cnt;
        issue(v.op, v.vlen, v.s1, v.s2, v.d, acc);
        wait_done(d0, 100, ok);
        if (ok) check($sformatf("v%0d_done_latency", idx), done_cyc - acc, v.lat);
        tick();
        check($sformatf("v%0d_ready_after_done", idx), {31'd0, cmd_ready}, 32'd1);
        check($sformatf("v%0d_done_count", idx), done_cnt - d0, 32'd1);
        check($sformatf("v%0d_write_count", idx), wr_addr_q.size() - wb, v.n);
        check($sformatf("v%0d_read_count", idx), rd_addr_q.size() - rb, v.n);
        for (int k = 0; k < v.n && (wb + k) < wr_addr_q.size(); k++) begin
            ea = v.d + AW'(k);
            ed = v.first + DW'(k) * v.step;
            check($sformatf("v%0d_waddr%0d", idx, k), 32'(wr_addr_q[wb + k]), 32'(ea));
            check($sformatf("v%0d_wdata%0d", idx, k), wr_data_q[wb + k], ed);
            check($sformatf("v%0d_vrf%0d", idx, k), vrf[ea], ed);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc, wb, rb, d0;
        logic ok;
        logic [DW-1:0] ed;

        //            op    vlen   s1     s2     d      abase   bval   first          step  n  lat
        vecs[0] = '{3'd0, 6'd4,  5'd0,  5'd8,  5'd16, 32'd0,   32'd10, 32'd10,        32'd1, 4, 6};
        vecs[1] = '{3'd0, 6'd0,  5'd0,  5'd8,  5'd16, 32'd0,   32'd10, 32'd0,         32'd0, 0, 1};
        vecs[2] = '{3'd3, 6'd2,  5'd4,  5'd6,  5'd10, 32'd7,   32'd9,  32'd254,       32'd0, 2, 4};
        vecs[3] = '{3'd2, 6'd3,  5'd0,  5'd3,  5'd6,  32'd3,   32'd5,  32'd15,        32'd5, 3, 5};
        vecs[4] = '{3'd5, 6'd3,  5'd12, 5'd20, 5'd24, 32'd100, 32'd7,  32'd0,         32'd0, 3, 5};
        vecs[5] = '{3'd1, 6'd5,  5'd20, 5'd26, 5'd0,  32'd50,  32'd8,  32'd42,        32'd1, 5, 7};
        vecs[6] = '{3'd1, 6'd3,  5'd16, 5'd20, 5'd24, 32'd0,   32'd2,  32'hFFFF_FFFE, 32'd1, 3, 5};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_vlen = '0;
        cmd_src1 = '0;
        cmd_src2 = '0;
        cmd_dst = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_rd_en", {31'd0, rf_rd_en}, 32'd0);
        check("reset_wr_en", {31'd0, rf_wr_en}, 32'd0);
        check("reset_alu_ena", {31'd0, alu_ena}, 32'd0);
        mon_on = 1'b1;

        for (int v = 0; v < 7; v++) run_vec(vecs[v], v);

        // vlen above VLMAX with wrapping source and destination bases
        clear_vrf();
        for (int j = 0; j < 32; j++) write_word(AW'(j), DW'(j));
        wb = wr_addr_q.size();
        rb = rd_addr_q.size();
        d0 = done_cnt;
        issue(3'd0, 6'd40, 5'd30, 5'd30, 5'd28, acc);
        wait_done(d0, 100, ok);
        if (ok) check("clamp_done_latency", done_cyc - acc, 32'd34);
        tick();
        check("clamp_write_count", wr_addr_q.size() - wb, 32'd32);
        check("clamp_read_count", rd_addr_q.size() - rb, 32'd32);
        for (int k = 0; k < 32 && (rb + k) < rd_addr_q.size(); k++)
            check($sformatf("clamp_raddr%0d", k), 32'(rd_addr_q[rb + k]), (30 + k) % 32);
        for (int k = 0; k < 32 && (wb + k) < wr_addr_q.size(); k++) begin
            // Elements 30/31 reread addresses 28/29, already overwritten by elements 0/1
            ed = (k < 30) ? DW'(2 * ((30 + k) % 32)) : ((k == 30) ? 32'd120 : 32'd124);
            check($sformatf("clamp_waddr%0d", k), 32'(wr_addr_q[wb + k]), (28 + k) % 32);
            check($sformatf("clamp_wdata%0d", k), wr_data_q[wb + k], ed);
        end

        // dst = src1 + 1: each read sees pre-write data, so no chaining
        clear_vrf();
        for (int k = 0; k < 4; k++) write_word(AW'(8 + k), 32'd1);
        d0 = done_cnt;
        issue(3'd0, 6'd4, 5'd0, 5'd8, 5'd1, acc);
        wait_done(d0, 100, ok);
        tick();
        for (int k = 1; k <= 4; k++) check($sformatf("overlap_vrf%0d", k), vrf[k], 32'd1);

        // Reset in the middle of an 8-element command
        clear_vrf();
        for (int k = 0; k < 8; k++) begin
            write_word(AW'(k), DW'(k));
            write_word(AW'(8 + k), 32'd1);
        end
        wb = wr_addr_q.size();
        d0 = done_cnt;
        issue(3'd0, 6'd8, 5'd0, 5'd8, 5'd16, acc);
        tick();
        check("abort_writes_before_reset", wr_addr_q.size() - wb, 32'd1);
        wb = wr_addr_q.size();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("abort_wr_en", {31'd0, rf_wr_en}, 32'd0);
        check("abort_rd_en", {31'd0, rf_rd_en}, 32'd0);
        repeat (12) tick();
        check("abort_no_more_writes", wr_addr_q.size() - wb, 32'd0);
        check("abort_no_done", done_cnt - d0, 32'd0);
        run_vec(vecs[0], 100);

        check("invariants", inv_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
